// File: rtl/icache_refill_pkg.sv
// Shared types and helpers for the I-cache AXI refill engine.
// The structs describe the default-width configuration of the engine.
package icache_refill_pkg;

  localparam int unsigned DefPlenWidth = 56;
  localparam int unsigned DefTidWidth  = 2;
  localparam int unsigned DefLineWidth = 128;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [DefPlenWidth-1:0] paddr;
    logic                    nc;
    logic [DefTidWidth-1:0]  tid;
  } refill_req_t;

  typedef struct packed {
    logic [DefTidWidth-1:0]  tid;
    logic [DefLineWidth-1:0] data;
    logic                    err;
  } refill_rtrn_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_cmd_t;

  // Cacheable misses fetch the whole line; nc misses fetch just the addressed beat.
  function automatic ar_cmd_t refill_ar_cmd(input logic [63:0] paddr, input logic nc,
                                            input int unsigned line_bytes,
                                            input int unsigned beat_bytes);
    ar_cmd_t     cmd;
    logic [63:0] mask;
    mask     = nc ? 64'(beat_bytes - 1) : 64'(line_bytes - 1);
    cmd.addr = paddr & ~mask;
    cmd.len  = nc ? 8'd0 : 8'(line_bytes / beat_bytes - 1);
    return cmd;
  endfunction

endpackage

// File: rtl/icache_refill_slot.sv
// One outstanding refill: tracks tag, kill and error state and assembles the line
// from R beats addressed to this slot.
module icache_refill_slot #(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned TidWidth     = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    alloc_i,
  input  logic                    alloc_nc_i,
  input  logic [TidWidth-1:0]     alloc_tid_i,
  input  logic                    beat_valid_i,
  input  logic [AxiDataWidth-1:0] beat_data_i,
  input  logic                    beat_err_i,
  input  logic                    beat_last_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [TidWidth-1:0]     tid_o,
  output logic [LineWidth-1:0]    line_o,
  output logic                    err_o
);
  localparam int unsigned Beats    = LineWidth / AxiDataWidth;
  localparam int unsigned CntWidth = $clog2(Beats + 1);

  logic                 busy_q, busy_d, kill_q, kill_d, nc_q, nc_d, err_q, err_d;
  logic [TidWidth-1:0]  tid_q, tid_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d, last_idx;
  logic [LineWidth-1:0] buf_q, buf_d;
  logic                 beat, room;

  always_comb begin
    busy_d   = busy_q;
    kill_d   = kill_q;
    nc_d     = nc_q;
    err_d    = err_q;
    tid_d    = tid_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    beat     = beat_valid_i & busy_q;
    last_idx = nc_q ? '0 : CntWidth'(Beats - 1);
    room     = (cnt_q <= last_idx);
    if (alloc_i) begin
      busy_d = 1'b1;
      kill_d = 1'b0;
      nc_d   = alloc_nc_i;
      tid_d  = alloc_tid_i;
      err_d  = 1'b0;
      cnt_d  = '0;
      buf_d  = '0;
    end else begin
      if (flush_i && busy_q) kill_d = 1'b1;
      if (beat) begin
        err_d = err_q | beat_err_i;
        // Beats past the burst length are dropped and the counter saturates.
        if (room) begin
          for (int w = 0; w < int'(Beats); w++) begin
            if (cnt_q == CntWidth'(w)) buf_d[w*AxiDataWidth +: AxiDataWidth] = beat_data_i;
          end
          cnt_d = cnt_q + CntWidth'(1);
        end
        if (beat_last_i) busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      kill_q <= 1'b0;
      nc_q   <= 1'b0;
      err_q  <= 1'b0;
      tid_q  <= '0;
      cnt_q  <= '0;
      buf_q  <= '0;
    end else begin
      busy_q <= busy_d;
      kill_q <= kill_d;
      nc_q   <= nc_d;
      err_q  <= err_d;
      tid_q  <= tid_d;
      cnt_q  <= cnt_d;
      buf_q  <= buf_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = beat & beat_last_i & ~kill_q & ~flush_i;
  assign tid_o  = tid_q;
  assign line_o = buf_d;
  assign err_o  = err_d;

endmodule

// File: rtl/icache_axi_refill_adapter.sv
// I-cache miss to AXI4 read adapter with several outstanding refills, reassembled per
// AXI ID so responses may return out of order or interleaved.
module icache_axi_refill_adapter
  import icache_refill_pkg::*;
#(
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned LineWidth      = 128,
  parameter int unsigned PlenWidth      = 56,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned NumOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  output logic                    busy_o,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [PlenWidth-1:0]    req_paddr_i,
  input  logic                    req_nc_i,
  input  logic [TidWidth-1:0]     req_tid_i,
  output logic                    rtrn_valid_o,
  output logic [TidWidth-1:0]     rtrn_tid_o,
  output logic [LineWidth-1:0]    rtrn_data_o,
  output logic                    rtrn_err_o,
  output logic                    spurious_o,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AxiAddrWidth-1:0] ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [1:0]              ar_burst_o,
  output logic [AxiIdWidth-1:0]   ar_id_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [AxiIdWidth-1:0]   r_id_i,
  input  logic [AxiDataWidth-1:0] r_data_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_last_i
);
  localparam int unsigned BeatBytes = AxiDataWidth / 8;
  localparam int unsigned LineBytes = LineWidth / 8;
  localparam int unsigned SlotIdxW  = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

  logic [NumOutstanding-1:0] slot_busy, slot_done, slot_alloc, slot_beat, slot_err;
  logic [TidWidth-1:0]       slot_tid  [NumOutstanding];
  logic [LineWidth-1:0]      slot_line [NumOutstanding];

  logic                    ar_valid_q, ar_valid_d;
  logic [AxiAddrWidth-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]              ar_len_q, ar_len_d;
  logic [AxiIdWidth-1:0]   ar_id_q, ar_id_d;
  logic                    rtrn_valid_q, rtrn_valid_d, rtrn_err_q, rtrn_err_d;
  logic [TidWidth-1:0]     rtrn_tid_q, rtrn_tid_d;
  logic [LineWidth-1:0]    rtrn_data_q, rtrn_data_d;
  logic                    spurious_q, spurious_d;

  logic                any_free, accept;
  logic [SlotIdxW-1:0] free_idx;
  logic [63:0]         paddr_ext;
  ar_cmd_t             cmd;
  logic                unused_resp;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int s = int'(NumOutstanding) - 1; s >= 0; s--) begin
      if (!slot_busy[s]) begin
        any_free = 1'b1;
        free_idx = SlotIdxW'(s);
      end
    end
    req_ready_o = any_free & (~ar_valid_q | ar_ready_i);
    accept      = req_valid_i & req_ready_o;
    for (int s = 0; s < int'(NumOutstanding); s++) begin
      slot_alloc[s] = accept && (free_idx == SlotIdxW'(s));
      slot_beat[s]  = r_valid_i && (r_id_i == AxiIdWidth'(s));
    end

    paddr_ext                  = '0;
    paddr_ext[PlenWidth-1:0]   = req_paddr_i;
    cmd                        = refill_ar_cmd(paddr_ext, req_nc_i, LineBytes, BeatBytes);
    // A new request may load the AR register in the same cycle the old one handshakes.
    ar_valid_d = ar_valid_q & ~ar_ready_i;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_id_d    = ar_id_q;
    if (accept) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = cmd.addr[AxiAddrWidth-1:0];
      ar_len_d   = cmd.len;
      ar_id_d    = AxiIdWidth'(free_idx);
    end

    spurious_d   = r_valid_i & ~|(slot_beat & slot_busy);
    rtrn_valid_d = |slot_done;
    rtrn_tid_d   = rtrn_tid_q;
    rtrn_data_d  = rtrn_data_q;
    rtrn_err_d   = rtrn_err_q;
    for (int s = 0; s < int'(NumOutstanding); s++) begin
      if (slot_done[s]) begin
        rtrn_tid_d  = slot_tid[s];
        rtrn_data_d = slot_line[s];
        rtrn_err_d  = slot_err[s];
      end
    end
  end

  for (genvar g = 0; g < NumOutstanding; g++) begin : gen_slot
    icache_refill_slot #(
      .AxiDataWidth(AxiDataWidth),
      .LineWidth   (LineWidth),
      .TidWidth    (TidWidth)
    ) u_slot (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .alloc_i     (slot_alloc[g]),
      .alloc_nc_i  (req_nc_i),
      .alloc_tid_i (req_tid_i),
      .beat_valid_i(slot_beat[g]),
      .beat_data_i (r_data_i),
      .beat_err_i  (r_resp_i[1]),
      .beat_last_i (r_last_i),
      .busy_o      (slot_busy[g]),
      .done_o      (slot_done[g]),
      .tid_o       (slot_tid[g]),
      .line_o      (slot_line[g]),
      .err_o       (slot_err[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ar_valid_q   <= 1'b0;
      ar_addr_q    <= '0;
      ar_len_q     <= '0;
      ar_id_q      <= '0;
      rtrn_valid_q <= 1'b0;
      rtrn_tid_q   <= '0;
      rtrn_data_q  <= '0;
      rtrn_err_q   <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      ar_valid_q   <= ar_valid_d;
      ar_addr_q    <= ar_addr_d;
      ar_len_q     <= ar_len_d;
      ar_id_q      <= ar_id_d;
      rtrn_valid_q <= rtrn_valid_d;
      rtrn_tid_q   <= rtrn_tid_d;
      rtrn_data_q  <= rtrn_data_d;
      rtrn_err_q   <= rtrn_err_d;
      spurious_q   <= spurious_d;
    end
  end

  assign unused_resp  = r_resp_i[0];
  assign busy_o       = |slot_busy | ar_valid_q;
  assign ar_valid_o   = ar_valid_q;
  assign ar_addr_o    = ar_addr_q;
  assign ar_len_o     = ar_len_q;
  assign ar_size_o    = 3'($clog2(BeatBytes));
  assign ar_burst_o   = AXI_BURST_INCR;
  assign ar_id_o      = ar_id_q;
  assign r_ready_o    = 1'b1;
  assign rtrn_valid_o = rtrn_valid_q;
  assign rtrn_tid_o   = rtrn_tid_q;
  assign rtrn_data_o  = rtrn_data_q;
  assign rtrn_err_o   = rtrn_err_q;
  assign spurious_o   = spurious_q;

endmodule

// File: tb/tb_icache_axi_refill_adapter.sv
// Self-checking bench for icache_axi_refill_adapter at default parameters: directed
// scenarios plus randomized interleaved refills checked against a line-level model.
module tb_icache_axi_refill_adapter;
  logic         clk = 1'b0;
  logic         rst_n, flush, busy;
  logic         req_valid, req_ready, req_nc;
  logic [55:0]  req_paddr;
  logic [1:0]   req_tid, rtrn_tid;
  logic         rtrn_valid, rtrn_err, spurious;
  logic [127:0] rtrn_data;
  logic         ar_valid, ar_ready;
  logic [63:0]  ar_addr;
  logic [7:0]   ar_len;
  logic [2:0]   ar_size;
  logic [1:0]   ar_burst;
  logic [3:0]   ar_id, r_id;
  logic         r_valid, r_ready, r_last;
  logic [63:0]  r_data;
  logic [1:0]   r_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_axi_refill_adapter dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .busy_o(busy),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_paddr_i(req_paddr),
    .req_nc_i(req_nc), .req_tid_i(req_tid),
    .rtrn_valid_o(rtrn_valid), .rtrn_tid_o(rtrn_tid), .rtrn_data_o(rtrn_data),
    .rtrn_err_o(rtrn_err), .spurious_o(spurious),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_len_o(ar_len),
    .ar_size_o(ar_size), .ar_burst_o(ar_burst), .ar_id_o(ar_id),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_id_i(r_id), .r_data_i(r_data),
    .r_resp_i(r_resp), .r_last_i(r_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [55:0] pa, input logic nc, input logic [1:0] tid);
    int n;
    n = 0;
    req_valid = 1'b1; req_paddr = pa; req_nc = nc; req_tid = tid;
    #1;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: req_ready=%0b after %0d cycles, want 1", req_ready, n);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp,
                           input logic last);
    r_valid = 1'b1; r_id = id; r_data = d; r_resp = resp; r_last = last;
    step();
    r_valid = 1'b0; r_last = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_paddr = '0; req_nc = 1'b0;
    req_tid = '0; ar_ready = 1'b1; r_valid = 1'b0; r_id = '0; r_data = '0; r_resp = '0;
    r_last = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    checks++;
    if ({ar_valid, rtrn_valid, rtrn_err, spurious, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: ar_v/rtrn_v/err/spur/busy=%05b want 00000",
               {ar_valid, rtrn_valid, rtrn_err, spurious, busy});
    end
    checks++;
    if (rtrn_data !== 128'h0) begin
      errors++; $display("FAIL reset_rtrn_data: got %h want 0", rtrn_data);
    end
    checks++;
    if ({req_ready, r_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: req/r ready=%02b want 11", {req_ready, r_ready});
    end
    // Mid-operation reset abandons the refill and the pending AR.
    send_req(56'h40, 1'b0, 2'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({busy, ar_valid} !== 2'b00) begin
      errors++; $display("FAIL midop_reset: busy/ar_valid=%02b want 00", {busy, ar_valid});
    end
  endtask

  task automatic test_cacheable();
    logic [63:0] a, b;
    a = rnd64(); b = rnd64();
    send_req(56'h8000_1238, 1'b0, 2'd1);
    checks++;
    if ({ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id} !==
        {1'b1, 64'h8000_1230, 8'd1, 3'd3, 2'b01, 4'd0}) begin
      errors++;
      $display("FAIL cache_ar: v=%0b addr=%h len=%0d size=%0d burst=%0d id=%0d want 1 80001230 1 3 1 0",
               ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id);
    end
    step();
    checks++;
    if (ar_valid !== 1'b0) begin errors++; $display("FAIL cache_ar_drop: ar_valid=%0b want 0", ar_valid); end
    send_beat(4'd0, a, 2'b00, 1'b0);
    checks++;
    if (rtrn_valid !== 1'b0) begin errors++; $display("FAIL cache_early_rtrn: got %0b want 0", rtrn_valid); end
    send_beat(4'd0, b, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, rtrn_tid, rtrn_err, rtrn_data} !== {1'b1, 2'd1, 1'b0, b, a}) begin
      errors++;
      $display("FAIL cache_rtrn: v=%0b tid=%0d err=%0b data=%h want 1 1 0 %h", rtrn_valid,
               rtrn_tid, rtrn_err, rtrn_data, {b, a});
    end
    step();
    checks++;
    if ({rtrn_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL cache_after: rtrn_v/busy=%02b want 00", {rtrn_valid, busy});
    end
  endtask

  task automatic test_nc();
    logic [63:0] d, e;
    d = rnd64(); e = rnd64();
    send_req(56'h1004, 1'b1, 2'd2);
    checks++;
    if ({ar_addr, ar_len, ar_size} !== {64'h1000, 8'd0, 3'd3}) begin
      errors++; $display("FAIL nc_ar: addr=%h len=%0d size=%0d want 1000 0 3", ar_addr, ar_len, ar_size);
    end
    step();
    send_beat(4'd0, d, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, rtrn_tid, rtrn_data} !== {1'b1, 2'd2, 64'h0, d}) begin
      errors++;
      $display("FAIL nc_rtrn: v=%0b tid=%0d data=%h want 1 2 %h", rtrn_valid, rtrn_tid,
               rtrn_data, {64'h0, d});
    end
    // Overrun: a second beat for a single-beat burst is discarded.
    send_req(56'h2008, 1'b1, 2'd3);
    step();
    send_beat(4'd0, d, 2'b00, 1'b0);
    send_beat(4'd0, e, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, rtrn_tid, rtrn_data} !== {1'b1, 2'd3, 64'h0, d}) begin
      errors++;
      $display("FAIL nc_overrun: v=%0b tid=%0d data=%h want 1 3 %h", rtrn_valid, rtrn_tid,
               rtrn_data, {64'h0, d});
    end
  endtask

  task automatic test_interleave();
    logic [63:0] w00, w01, w10, w11;
    w00 = rnd64(); w01 = rnd64(); w10 = rnd64(); w11 = rnd64();
    send_req(56'h100, 1'b0, 2'd0);
    send_req(56'h21f, 1'b0, 2'd1);
    checks++;
    if ({ar_valid, ar_addr, ar_id, req_ready} !== {1'b1, 64'h210, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL ilv_second_ar: v=%0b addr=%h id=%0d ready=%0b want 1 210 1 0", ar_valid,
               ar_addr, ar_id, req_ready);
    end
    step();
    send_beat(4'd1, w10, 2'b00, 1'b0);
    send_beat(4'd0, w00, 2'b00, 1'b0);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL ilv_full: req_ready=%0b want 0", req_ready); end
    send_beat(4'd1, w11, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, rtrn_tid, rtrn_data} !== {1'b1, 2'd1, w11, w10}) begin
      errors++;
      $display("FAIL ilv_rtrn1: v=%0b tid=%0d data=%h want 1 1 %h", rtrn_valid, rtrn_tid,
               rtrn_data, {w11, w10});
    end
    send_beat(4'd0, w01, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, rtrn_tid, rtrn_data} !== {1'b1, 2'd0, w01, w00}) begin
      errors++;
      $display("FAIL ilv_rtrn0: v=%0b tid=%0d data=%h want 1 0 %h", rtrn_valid, rtrn_tid,
               rtrn_data, {w01, w00});
    end
  endtask

  task automatic test_ar_stall();
    logic [63:0] a, b, c, d;
    a = rnd64(); b = rnd64(); c = rnd64(); d = rnd64();
    ar_ready = 1'b0;
    send_req(56'h3_0047, 1'b0, 2'd2);
    req_valid = 1'b1; req_paddr = 56'h5_0008; req_nc = 1'b1; req_tid = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({ar_valid, ar_addr, ar_len, ar_id, req_ready} !== {1'b1, 64'h3_0040, 8'd1, 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: v=%0b addr=%h len=%0d id=%0d ready=%0b want 1 30040 1 0 0",
                 i, ar_valid, ar_addr, ar_len, ar_id, req_ready);
      end
    end
    ar_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    checks++;
    if ({ar_valid, ar_addr, ar_len, ar_id} !== {1'b1, 64'h5_0008, 8'd0, 4'd1}) begin
      errors++;
      $display("FAIL stall_b2b_ar: v=%0b addr=%h len=%0d id=%0d want 1 50008 0 1", ar_valid,
               ar_addr, ar_len, ar_id);
    end
    step();
    send_beat(4'd0, a, 2'b00, 1'b0);
    send_beat(4'd0, b, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, rtrn_tid, rtrn_data} !== {1'b1, 2'd2, b, a}) begin
      errors++; $display("FAIL stall_rtrn0: v=%0b tid=%0d data=%h want 1 2 %h", rtrn_valid,
                         rtrn_tid, rtrn_data, {b, a});
    end
    send_beat(4'd1, c, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, rtrn_tid, rtrn_data} !== {1'b1, 2'd3, 64'h0, c}) begin
      errors++; $display("FAIL stall_rtrn1: v=%0b tid=%0d data=%h want 1 3 %h", rtrn_valid,
                         rtrn_tid, rtrn_data, {64'h0, c});
    end
    d = d;
  endtask

  task automatic test_flush();
    logic [63:0] a, b, c, d;
    a = rnd64(); b = rnd64(); c = rnd64(); d = rnd64();
    // Flush alone after the first beat.
    send_req(56'h600, 1'b0, 2'd1);
    step();
    send_beat(4'd0, a, 2'b00, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    send_beat(4'd0, b, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL flush_kill: rtrn_v/busy=%02b want 00", {rtrn_valid, busy});
    end
    // Request accepted in the flush cycle survives; the older one is killed.
    send_req(56'h700, 1'b0, 2'd2);
    step();
    send_beat(4'd0, a, 2'b00, 1'b0);
    flush = 1'b1; req_valid = 1'b1; req_paddr = 56'h880; req_nc = 1'b0; req_tid = 2'd3;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_accept_ready: got %0b want 1", req_ready); end
    step();
    flush = 1'b0; req_valid = 1'b0;
    step();
    send_beat(4'd0, b, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, busy} !== 2'b01) begin
      errors++; $display("FAIL flush_partial: rtrn_v/busy=%02b want 01", {rtrn_valid, busy});
    end
    send_beat(4'd1, c, 2'b00, 1'b0);
    send_beat(4'd1, d, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, rtrn_tid, rtrn_data, busy} !== {1'b1, 2'd3, d, c, 1'b0}) begin
      errors++; $display("FAIL flush_survivor: v=%0b tid=%0d data=%h busy=%0b want 1 3 %h 0",
                         rtrn_valid, rtrn_tid, rtrn_data, busy, {d, c});
    end
    // Flush while the AR is still pending: AR still issues, burst drains silently.
    ar_ready = 1'b0;
    send_req(56'h900, 1'b0, 2'd0);
    flush = 1'b1; step(); flush = 1'b0;
    checks++;
    if (ar_valid !== 1'b1) begin errors++; $display("FAIL flush_ar_kept: ar_valid=%0b want 1", ar_valid); end
    ar_ready = 1'b1; step();
    send_beat(4'd0, a, 2'b00, 1'b0);
    send_beat(4'd0, b, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL flush_ar_pending: rtrn_v/busy=%02b want 00", {rtrn_valid, busy});
    end
  endtask

  task automatic test_err_spurious();
    logic [63:0] a, b;
    a = rnd64(); b = rnd64();
    send_req(56'hA00, 1'b0, 2'd1);
    step();
    send_beat(4'd0, a, 2'b10, 1'b0);
    send_beat(4'd0, b, 2'b00, 1'b1);
    checks++;
    if ({rtrn_valid, rtrn_err, rtrn_data} !== {1'b1, 1'b1, b, a}) begin
      errors++; $display("FAIL err_first_beat: v=%0b err=%0b data=%h want 1 1 %h", rtrn_valid,
                         rtrn_err, rtrn_data, {b, a});
    end
    send_req(56'hB00, 1'b0, 2'd2);
    step();
    send_beat(4'd0, a, 2'b01, 1'b0);
    send_beat(4'd0, b, 2'b01, 1'b1);
    checks++;
    if ({rtrn_valid, rtrn_err} !== 2'b10) begin
      errors++; $display("FAIL err_exokay: v/err=%02b want 10", {rtrn_valid, rtrn_err});
    end
    send_req(56'hC00, 1'b0, 2'd3);
    step();
    send_beat(4'd0, a, 2'b00, 1'b0);
    send_beat(4'd0, b, 2'b11, 1'b1);
    checks++;
    if ({rtrn_valid, rtrn_err} !== 2'b11) begin
      errors++; $display("FAIL err_last_beat: v/err=%02b want 11", {rtrn_valid, rtrn_err});
    end
    send_beat(4'd3, a, 2'b00, 1'b1);
    checks++;
    if ({spurious, rtrn_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL spurious_id3: spur/rtrn_v/busy=%03b want 100", {spurious, rtrn_valid, busy});
    end
    step();
    checks++;
    if (spurious !== 1'b0) begin errors++; $display("FAIL spurious_pulse: got %0b want 0", spurious); end
    send_beat(4'd1, b, 2'b00, 1'b0);
    checks++;
    if (spurious !== 1'b1) begin errors++; $display("FAIL spurious_idle1: got %0b want 1", spurious); end
  endtask

  // Model: each miss is a line built from its own beats; the first beats of a burst fill
  // words in order, the return carries the tag and the OR of RRESP[1].
  task automatic test_random();
    logic [63:0]  words [2][2];
    logic [55:0]  pa;
    logic [63:0]  exp_addr;
    logic [127:0] exp_line;
    logic [1:0]   tids [2];
    logic [1:0]   resp;
    logic         ncs [2], errx [2], killed [2];
    int           nb [2], sent [2], nreq, s;
    for (int it = 0; it < 60; it++) begin
      nreq = int'($urandom_range(1, 2));
      for (int k = 0; k < nreq; k++) begin
        pa = 56'({$urandom, $urandom});
        ncs[k] = 1'($urandom); tids[k] = 2'($urandom);
        words[k][0] = rnd64(); words[k][1] = rnd64();
        nb[k] = ncs[k] ? 1 : 2; sent[k] = 0; errx[k] = 1'b0; killed[k] = 1'b0;
        exp_addr = 64'(pa) & (ncs[k] ? ~64'h7 : ~64'hF);
        send_req(pa, ncs[k], tids[k]);
        checks++;
        if ({ar_valid, ar_addr, ar_len, ar_id} !== {1'b1, exp_addr, 8'(nb[k] - 1), 4'(k)}) begin
          errors++;
          $display("FAIL rnd_ar[%0d.%0d]: v=%0b addr=%h len=%0d id=%0d want 1 %h %0d %0d", it, k,
                   ar_valid, ar_addr, ar_len, ar_id, exp_addr, nb[k] - 1, k);
        end
      end
      step();
      while (sent[0] < nb[0] || (nreq == 2 && sent[1] < nb[1])) begin
        s = int'($urandom_range(0, nreq - 1));
        if (sent[s] == nb[s]) s = 1 - s;
        if ($urandom_range(0, 9) == 0) begin
          flush = 1'b1; step(); flush = 1'b0;
          for (int k = 0; k < nreq; k++) if (sent[k] < nb[k]) killed[k] = 1'b1;
        end
        resp = 2'($urandom_range(0, 7) == 0 ? 2 : 0);
        errx[s] = errx[s] | resp[1];
        send_beat(4'(s), words[s][sent[s]], resp, sent[s] == nb[s] - 1);
        sent[s]++;
        exp_line = ncs[s] ? {64'h0, words[s][0]} : {words[s][1], words[s][0]};
        checks++;
        if (sent[s] < nb[s] || killed[s]) begin
          if (rtrn_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_no_rtrn[%0d]: rtrn_valid=%0b want 0", it, rtrn_valid);
          end
        end else if ({rtrn_valid, rtrn_tid, rtrn_err, rtrn_data} !==
                     {1'b1, tids[s], errx[s], exp_line}) begin
          errors++;
          $display("FAIL rnd_rtrn[%0d]: v=%0b tid=%0d err=%0b data=%h want 1 %0d %0b %h", it,
                   rtrn_valid, rtrn_tid, rtrn_err, rtrn_data, tids[s], errx[s], exp_line);
        end
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rnd_idle[%0d]: busy=%0b want 0", it, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_cacheable();
    test_nc();
    test_interleave();
    test_ar_stall();
    test_flush();
    test_err_spurious();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_axi_refill_adapter.md
Name: icache_axi_refill_adapter

Overview:
Parametrised I-cache refill engine between the L1 instruction cache miss interface and an AXI4 read-only master port. It supports configurable AXI data width and cache line width, and up to NumOutstanding concurrent refills. Responses are reassembled per AXI ID, so they may return out of order or with interleaved beats. Flush kills refills that are in flight, and AXI read errors are reported back to the cache. It replaces the single-outstanding, fixed 64-bit refill shim on the fetch path.

Parameters:
AxiAddrWidth, 64, AR address width
AxiDataWidth, 64, R data width; power of 2, 32..LineWidth
AxiIdWidth, 4, AXI ID width; must be >= $clog2(NumOutstanding)
LineWidth, 128, cache line width in bits; power of 2, >= AxiDataWidth
PlenWidth, 56, physical address width; must be <= AxiAddrWidth
TidWidth, 2, cache transaction tag width
NumOutstanding, 2, refill slots; 1..8

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
flush_i  in  1  kill all refills accepted before this cycle
busy_o  out  1  any slot busy or AR pending
req_valid_i  in  1  miss request valid
req_ready_o  out  1  request accepted when valid&ready
req_paddr_i  in  PlenWidth  miss physical address
req_nc_i  in  1  non-cacheable single-word access
req_tid_i  in  TidWidth  cache tag echoed on return
rtrn_valid_o  out  1  single-cycle return pulse; no backpressure
rtrn_tid_o  out  TidWidth  tag of completed refill
rtrn_data_o  out  LineWidth  assembled line
rtrn_err_o  out  1  any beat had RRESP[1]=1
spurious_o  out  1  pulse: R beat with ID of an idle slot
ar_valid_o  out  1  AXI AR valid
ar_ready_i  in  1  AXI AR ready
ar_addr_o  out  AxiAddrWidth  AR address
ar_len_o  out  8  AR burst length
ar_size_o  out  3  AR size
ar_burst_o  out  2  AR burst type; constant 2'b01 (INCR)
ar_id_o  out  AxiIdWidth  AR ID (slot index, zero-extended)
r_valid_i  in  1  R valid
r_ready_o  out  1  R ready; constant 1
r_id_i  in  AxiIdWidth  R ID
r_data_i  in  AxiDataWidth  R data
r_resp_i  in  2  R response
r_last_i  in  1  R last beat

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - all slots free; ar_valid_o=0; rtrn_valid_o=0; rtrn_data_o=0; rtrn_err_o=0; spurious_o=0; busy_o=0.
  - Mid-operation reset abandons all slots. Pending AXI responses are the system's responsibility.
- Derived constants: BeatsPerLine = LineWidth/AxiDataWidth; BeatBytes = AxiDataWidth/8.
- req_ready_o = (a free slot exists in registered state) & (!ar_valid_o | ar_ready_i).
- On accept:
  - allocate the lowest-index free slot; store tid and nc; clear beat counter, buffer and err flag; kill=0.
  - load the AR register:
    - cacheable: addr = paddr aligned down to LineWidth/8 bytes; len = BeatsPerLine-1.
    - nc: addr = paddr aligned down to BeatBytes; len = 0.
    - size = $clog2(BeatBytes); id = slot index.
- ar_valid_o rises the cycle after accept. All AR fields are held stable until ar_ready_i (AXI rule).
- A back-to-back accept is allowed in the same cycle as the AR handshake.
- R beat (r_valid_i=1), slot s = r_id_i:
  - If slot s is free: drop the beat and pulse spurious_o on the next cycle.
  - Otherwise: write r_data_i into word[beat_cnt] of slot s; increment beat_cnt; set err if r_resp_i[1].
  - nc refill: the single word goes to word 0; upper words stay 0.
- On r_last_i for a busy slot:
  - next cycle: rtrn_valid_o=1 with that slot's tid, assembled data, and err including the last beat.
  - This is suppressed (no pulse) if the slot is killed.
  - The slot frees at the same edge but becomes allocatable only from the following cycle.
- At most one completion per cycle, because R delivers at most one beat per cycle.
- flush_i:
  - sets kill on every busy slot, including one receiving its last beat that cycle (return suppressed).
  - also kills a slot whose AR is still pending. The AR is still issued and the burst is drained.
  - A request accepted in the same cycle as flush_i is NOT killed.
- busy_o = any slot busy | ar_valid_o.
- Beat overrun (beat_cnt would exceed len) is ignored: the counter saturates and data is discarded.

Decomposition:
- Package icache_refill_pkg:
  - refill_req_t {paddr, nc, tid}
  - refill_rtrn_t {tid, data, err}
  - AXI_BURST_INCR constant
  - function to compute ar_len and aligned address from (paddr, nc)
- One sub-module, icache_refill_slot, instantiated NumOutstanding times. It holds busy/kill/nc/tid/err, the beat counter and the LineWidth buffer, and raises a done pulse.
- The top level holds the free-slot priority encoder, the AR register and the return register.

Test Plan:
1. Default params, req paddr=0x8000_1238 nc=0 tid=1 → AR addr=0x8000_1230 len=1 size=3 burst=1 id=0; R beats id0 A, then B with last → next cycle rtrn_valid_o=1, tid=1, data={B,A}, err=0.
2. nc=1, paddr=0x1004 → AR addr=0x1000 len=0; R data D last → rtrn_data_o[63:0]=D, [127:64]=0.
3. Two reqs: tid0 gets slot0 and tid1 gets slot1. R beats arrive id1,id0,id1(last),id0(last) → rtrn tid1 then tid0, both lines correct, req_ready_o=0 while both slots busy.
4. ar_ready_i=0 for 5 cycles → AR fields stable, ar_valid_o held, req_ready_o=0; handshake on cycle 6 with a new req in the same cycle → that req is accepted.
5. Flush after beat 0 of slot0 → no rtrn for slot0, slot freed after last beat, busy_o=0 the next cycle; a req accepted in the flush cycle still returns.
6. Beat with r_resp=2'b10 → rtrn_err_o=1. A beat with id=3 while slot3 is idle → spurious_o pulses and no return is produced.
